// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Optional build macro used by this slice: MEM_LSU_MISALIGN_CHECK_EN.
package mem_lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} lsu_state_t;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} lsu_size_t;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;
  localparam logic [2:0] FUNC3_SW  = 3'b010;

  // Unsupported codes (011, 110, 111) fall through to a full word access.
  function automatic lsu_size_t func3_size(input logic [2:0] func3);
    case (func3)
      FUNC3_LB, FUNC3_LBU: return SIZE_B;
      FUNC3_LH, FUNC3_LHU: return SIZE_H;
      default:             return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    case (func3_size(func3))
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Request channel uses valid/ready; the response channel is valid-only.
interface mem_lsu_if #(parameter int ADDR_W = 32) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_rdata;
  logic              mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

endinterface

// File: rtl/mem_lsu_fmt.sv
// Combinational lane formatting: store strobes/replicated data and load
// byte/half extraction with sign or zero extension.
module mem_lsu_fmt
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  lsu_size_t   size;
  logic        is_unsigned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size        = func3_size(func3);
    is_unsigned = func3[2];
    byte_sel    = load_word[{addr_lo, 3'b000} +: 8];
    half_sel    = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    wstrb       = 4'hF;
    wdata       = store_data;
    load_data   = load_word;
    case (size)
      SIZE_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SIZE_H: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus transaction per load/store, stall flags
// asserted from the start cycle, results held until the pipeline advances.
// Build option: define MEM_LSU_MISALIGN_CHECK_EN to fault misaligned accesses without using the bus.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_i_start,
  input  logic        MEM_i_mem_to_reg,
  input  logic        MEM_i_write_mem,
  input  logic [2:0]  MEM_i_func3,
  input  logic [31:0] MEM_i_ALU_ALUout,
  input  logic [31:0] MEM_i_rs2_data,
  input  logic        MEM_i_advance,
  output logic        MEM_rvalid,
  output logic        MEM_wready,
  output logic [31:0] MEM_o_rdata,
  output logic        MEM_o_access_fault,
  mem_lsu_if.master   bus
);

  lsu_state_t        state_q, state_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              req_valid_q, req_valid_d;
  logic              req_wen_q, req_wen_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;

  logic        start_ok, start_load, start_store, misalign, busy;
  logic [2:0]  fmt_func3;
  logic [1:0]  fmt_addr_lo;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata, fmt_load;

  // The formatter serves the issuing instruction at start and the latched one in RSP.
  assign fmt_func3   = (state_q == RSP) ? func3_q   : MEM_i_func3;
  assign fmt_addr_lo = (state_q == RSP) ? addr_lo_q : MEM_i_ALU_ALUout[1:0];

  mem_lsu_fmt u_fmt (
    .func3      (fmt_func3),
    .addr_lo    (fmt_addr_lo),
    .store_data (MEM_i_rs2_data),
    .load_word  (bus.mem_rsp_rdata),
    .wstrb      (fmt_wstrb),
    .wdata      (fmt_wdata),
    .load_data  (fmt_load)
  );

  always_comb begin
    start_ok    = MEM_i_start && (state_q == IDLE || (state_q == DONE && MEM_i_advance));
    start_load  = start_ok && MEM_i_mem_to_reg;
    start_store = start_ok && MEM_i_write_mem && !MEM_i_mem_to_reg;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    misalign    = is_misaligned(MEM_i_func3, MEM_i_ALU_ALUout[1:0]);
`else
    misalign    = 1'b0;
`endif
    busy        = (state_q == REQ) || (state_q == RSP);
  end

  // Stall flags drop combinationally in the start cycle so the pipeline never slips.
  assign MEM_rvalid = !((busy && is_load_q)  || start_load);
  assign MEM_wready = !((busy && is_store_q) || start_store);

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    func3_d     = func3_q;
    addr_lo_d   = addr_lo_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    req_valid_d = req_valid_q;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && MEM_i_advance) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end
        if (start_load || start_store) begin
          is_load_d  = start_load;
          is_store_d = start_store;
          func3_d    = MEM_i_func3;
          addr_lo_d  = MEM_i_ALU_ALUout[1:0];
          if (misalign) begin
            state_d = DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_wen_d   = start_store;
            req_addr_d  = {MEM_i_ALU_ALUout[ADDR_W-1:2], 2'b00};
            req_wdata_d = start_store ? fmt_wdata : '0;
            req_wstrb_d = start_store ? fmt_wstrb : '0;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d     = RSP;
          req_valid_d = 1'b0;
        end
      end
      RSP: begin
        if (bus.mem_rsp_valid) begin
          state_d = DONE;
          if (bus.mem_rsp_err) begin
            fault_d = 1'b1;
            if (is_load_q) rdata_d = '0;
          end else if (is_load_q) begin
            rdata_d = fmt_load;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      func3_q     <= '0;
      addr_lo_q   <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      is_store_q  <= is_store_d;
      func3_q     <= func3_d;
      addr_lo_q   <= addr_lo_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      req_valid_q <= req_valid_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
    end
  end

  assign MEM_o_rdata        = rdata_q;
  assign MEM_o_access_fault = fault_q;
  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_req_wen    = req_wen_q;
  assign bus.mem_req_addr   = req_addr_q;
  assign bus.mem_req_wdata  = req_wdata_q;
  assign bus.mem_req_wstrb  = req_wstrb_q;

  // The pipeline must not advance while a bus access is outstanding.
  advance_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(MEM_i_advance && (state_q == REQ || state_q == RSP)));

endmodule
